lut_train_driver: RTL and testbench

Training-sequence driver for the 4-input Boolean LUT learner. It holds a small dataset of (x, y) samples written by a host and replays them to the learner epoch by epoch. It judges each learner prediction, counts mismatches per epoch, and stops on the first error-free epoch or after a maximum epoch count. On convergence it freezes the learned 16-bit truth table for downstream use.

---
 rtl/lut_train_pkg.sv | 6 +
 rtl/lut_sample_mem.sv | 21 ++
 rtl/lut_train_driver.sv | 114 +++++++++++
 tb/tb_lut_train_driver.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lut_train_pkg.sv
// lut_train_pkg: shared state type and widths for the LUT learner and its training driver
package lut_train_pkg;
    localparam int X_W = 4;
    localparam int P_W = 1 << X_W;
    typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_t;
endpackage

// File: rtl/lut_sample_mem.sv
// lut_sample_mem: training dataset, {x, y} per entry, sync write and async read
module lut_sample_mem
    import lut_train_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [X_W:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [X_W:0]  rdata
);
    logic [X_W:0] mem [DEPTH];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    assign rdata = mem[raddr];
endmodule

// File: rtl/lut_train_driver.sv
// lut_train_driver: replays a stored dataset to a LUT learner epoch by epoch and
// stops on the first error-free epoch or at the epoch limit
module lut_train_driver
    import lut_train_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW = $clog2(DEPTH),
    parameter int DWELL = 2,
    parameter int MAX_EPOCHS = 255,
    parameter int EPW = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           wr_en,
    input  logic [AW-1:0]  wr_addr,
    input  logic [X_W-1:0] wr_x,
    input  logic           wr_y,
    input  logic [AW:0]    n_samples,
    input  logic           start,
    output logic [X_W-1:0] x_o,
    output logic           y_o,
    input  logic           pred_i,
    input  logic [P_W-1:0] p_i,
    output logic           busy,
    output logic           done,
    output logic           converged,
    output logic [EPW-1:0] epoch_cnt,
    output logic [AW:0]    err_cnt,
    output logic [P_W-1:0] p_final
);
    localparam logic [AW:0]    N_MAX  = (AW+1)'(DEPTH);
    localparam logic [3:0]     D_LAST = 4'(DWELL - 1);
    localparam logic [EPW-1:0] E_MAX  = EPW'(MAX_EPOCHS);

    state_t        state, state_nx;
    logic [AW-1:0] idx, rd_addr;
    logic [3:0]    dwell;
    logic [AW:0]   n_lat;
    logic [X_W:0]  rd_data;
    logic          accept, n_bad, judge, last, epoch_last;

    assign accept     = start && (state == IDLE || state == DONE);
    assign n_bad      = n_samples == '0 || n_samples > N_MAX;
    assign judge      = state == RUN && dwell == D_LAST;
    assign last       = {1'b0, idx} == n_lat - (AW+1)'(1);
    assign epoch_last = epoch_cnt + EPW'(1) == E_MAX;
    assign busy       = state == RUN || state == CHECK;
    assign done       = state == DONE;
    // Look one sample ahead while running so the next sample loads with no bubble
    assign rd_addr    = (state == RUN) ? idx + AW'(1) : '0;

    lut_sample_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk   (clk),
        .we    (wr_en && !busy),
        .waddr (wr_addr),
        .wdata ({wr_x, wr_y}),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: if (start) state_nx = n_bad ? DONE : RUN;
            RUN:        if (judge && last) state_nx = CHECK;
            CHECK:      state_nx = (err_cnt == '0 || epoch_last) ? DONE : RUN;
            default:    state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_o       <= '0;
            y_o       <= 1'b0;
            idx       <= '0;
            dwell     <= '0;
            n_lat     <= '0;
            err_cnt   <= '0;
            epoch_cnt <= '0;
            converged <= 1'b0;
            p_final   <= '0;
        end else if (accept) begin
            n_lat     <= n_samples;
            idx       <= '0;
            dwell     <= '0;
            err_cnt   <= '0;
            epoch_cnt <= '0;
            converged <= 1'b0;
            if (!n_bad) {x_o, y_o} <= rd_data;
        end else if (state == RUN) begin
            // Only the last cycle of each dwell is judged; earlier cycles let the learner settle
            dwell <= judge ? '0 : dwell + 4'd1;
            if (judge && pred_i != y_o) err_cnt <= err_cnt + (AW+1)'(1);
            if (judge && !last) begin
                idx        <= idx + AW'(1);
                {x_o, y_o} <= rd_data;
            end
        end else if (state == CHECK) begin
            epoch_cnt <= epoch_cnt + EPW'(1);
            if (err_cnt == '0) begin
                converged <= 1'b1;
                p_final   <= p_i;
            end else if (!epoch_last) begin
                err_cnt    <= '0;
                idx        <= '0;
                {x_o, y_o} <= rd_data;
            end
        end
    end
endmodule

// File: tb/tb_lut_train_driver.sv
// tb_lut_train_driver: randomized self-checking bench with a timing/error model of training
module tb_lut_train_driver;
    import lut_train_pkg::*;
    localparam int DEPTH = 16, AW = 4, DW = 3, MAXE = 3, EPW = 8;

    logic clk = 1'b0, rst = 1'b1;
    logic wr_en = 1'b0, wr_y = 1'b0, start = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [3:0] wr_x = '0;
    logic [AW:0] n_samples = '0;
    logic [3:0] x_o;
    logic y_o, pred_i, busy, done, converged;
    logic [15:0] p_i, p_final;
    logic [EPW-1:0] epoch_cnt;
    logic [AW:0] err_cnt;

    logic learn = 1'b0, pred_drv = 1'b0, ly = 1'b0;
    logic [15:0] p_drv = '0, lp = '0, exp_pf = '0;
    logic [3:0] lx = '0;
    logic [3:0] mdl_x [DEPTH];
    logic mdl_y [DEPTH];
    logic mis [MAXE][DEPTH];
    int vec = 0, bad = 0;

    lut_train_driver #(.DEPTH(DEPTH), .AW(AW), .DWELL(DW), .MAX_EPOCHS(MAXE), .EPW(EPW)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_x(wr_x), .wr_y(wr_y),
        .n_samples(n_samples), .start(start), .x_o(x_o), .y_o(y_o), .pred_i(pred_i), .p_i(p_i),
        .busy(busy), .done(done), .converged(converged), .epoch_cnt(epoch_cnt),
        .err_cnt(err_cnt), .p_final(p_final)
    );

    always #5 clk = ~clk;

    // Reference learner: registered input, memorises the label it is shown
    always @(posedge clk) begin
        lx <= x_o;
        ly <= y_o;
        if (learn && busy) lp[lx] <= ly;
    end
    assign pred_i = learn ? lp[lx] : pred_drv;
    assign p_i = learn ? lp : p_drv;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic write_mem(input int a, input logic [3:0] x, input logic y);
        wr_en = 1'b1; wr_addr = AW'(a); wr_x = x; wr_y = y;
        tick;
        wr_en = 1'b0;
        mdl_x[a] = x; mdl_y[a] = y;
    endtask

    task automatic start_run(input int n);
        n_samples = (AW+1)'(n); start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    task automatic clear_mis;
        for (int e = 0; e < MAXE; e++)
            for (int s = 0; s < DEPTH; s++) mis[e][s] = 1'b0;
    endtask

    // Expected outcome: epochs run until one has no judged mismatches or the limit is hit
    task automatic model(input int n, output int ep, output int err, output logic conv);
        ep = 0; err = 0; conv = 1'b0;
        while (!conv && ep < MAXE) begin
            err = 0;
            for (int s = 0; s < n; s++) err += int'(mis[ep][s]);
            ep++;
            conv = (err == 0);
        end
    endtask

    // Cycle 0 is the first busy cycle; each epoch is n*DW sample cycles then one check cycle
    task automatic run_train(input int n, input int inj, output int cyc, output int seq_bad);
        int L, e, r;
        L = n * DW + 1; cyc = 0; seq_bad = 0;
        while (done !== 1'b1 && cyc < 200) begin
            e = cyc / L; r = cyc % L;
            wr_en = (cyc == inj); start = (cyc == inj);
            wr_addr = '0; wr_x = ~mdl_x[0]; wr_y = ~mdl_y[0];
            if (busy !== 1'b1) seq_bad++;
            if (r < n * DW) begin
                if (x_o !== mdl_x[r / DW] || y_o !== mdl_y[r / DW]) seq_bad++;
                pred_drv = (r % DW == DW - 1) ? (mdl_y[r / DW] ^ (e < MAXE && mis[e % MAXE][r / DW]))
                                              : 1'($urandom);
            end
            tick;
            cyc++;
        end
        wr_en = 1'b0; start = 1'b0;
    endtask

    task automatic test_reset;
        tick; tick;
        vec++;
        if ({x_o, y_o, busy, done, converged, epoch_cnt, err_cnt, p_final} !== '0) begin
            bad++;
            $display("FAIL reset_init: x=%h y=%b busy=%b done=%b conv=%b ep=%0d err=%0d pf=%h, want all zero",
                     x_o, y_o, busy, done, converged, epoch_cnt, err_cnt, p_final);
        end
        rst = 1'b0;
        tick;
        for (int a = 0; a < 4; a++) write_mem(a, 4'($urandom) | 4'd1, 1'($urandom));
        learn = 1'b1;
        start_run(4);
        repeat (4) tick;
        vec++;
        if (busy !== 1'b1 || x_o === 4'd0) begin
            bad++;
            $display("FAIL reset_prerun: busy=%b x=%h, want busy=1 x=nonzero", busy, x_o);
        end
        #2 rst = 1'b1;
        #1;
        vec++;
        if ({x_o, y_o, busy, done, converged, epoch_cnt, err_cnt, p_final} !== '0) begin
            bad++;
            $display("FAIL reset_midrun: x=%h y=%b busy=%b done=%b conv=%b ep=%0d err=%0d pf=%h, want all zero",
                     x_o, y_o, busy, done, converged, epoch_cnt, err_cnt, p_final);
        end
        tick;
        rst = 1'b0;
        tick; tick;
        vec++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_after: busy=%b done=%b, want 0 0", busy, done);
        end
        learn = 1'b0;
    endtask

    task automatic test_convergence;
        int cyc, sb;
        logic [3:0] xa;
        for (int a = 0; a < 16; a++) begin
            xa = 4'(a);
            write_mem(a, xa, xa[0] ^ xa[3]);
            exp_pf[a] = xa[0] ^ xa[3];
        end
        learn = 1'b1;
        start_run(16);
        run_train(16, -1, cyc, sb);
        vec++;
        if (sb !== 0 || cyc !== 49 || busy !== 1'b0 || converged !== 1'b1 || err_cnt !== 0 ||
            epoch_cnt !== 1 || p_final !== exp_pf) begin
            bad++;
            $display("FAIL convergence: seq_bad=%0d cyc=%0d busy=%b conv=%b err=%0d ep=%0d pf=%h, want 0 49 0 1 0 1 %h",
                     sb, cyc, busy, converged, err_cnt, epoch_cnt, p_final, exp_pf);
        end
        learn = 1'b0;
    endtask

    task automatic test_empty;
        int n;
        for (int k = 0; k < 2; k++) begin
            n = k ? 17 : 0;
            start_run(n);
            vec++;
            if (done !== 1'b1 || busy !== 1'b0 || converged !== 1'b0 || epoch_cnt !== 0) begin
                bad++;
                $display("FAIL empty_n%0d: done=%b busy=%b conv=%b ep=%0d, want 1 0 0 0",
                         n, done, busy, converged, epoch_cnt);
            end
            tick;
            vec++;
            if (busy !== 1'b0 || done !== 1'b1) begin
                bad++;
                $display("FAIL empty_hold_n%0d: busy=%b done=%b, want 0 1", n, busy, done);
            end
        end
    endtask

    task automatic test_dwell;
        int cyc, sb, ep, err;
        logic conv;
        for (int a = 0; a < 4; a++) write_mem(a, 4'($urandom), 1'($urandom));
        clear_mis;
        for (int e = 0; e < MAXE; e++) mis[e][2] = 1'b1;
        p_drv = 16'($urandom);
        model(4, ep, err, conv);
        start_run(4);
        run_train(4, -1, cyc, sb);
        vec++;
        if (sb !== 0 || cyc !== ep * 13) begin
            bad++;
            $display("FAIL dwell_seq: seq_bad=%0d cyc=%0d, want 0 %0d", sb, cyc, ep * 13);
        end
        vec++;
        if (converged !== conv || int'(err_cnt) !== err || int'(epoch_cnt) !== ep || p_final !== exp_pf) begin
            bad++;
            $display("FAIL dwell_result: conv=%b err=%0d ep=%0d pf=%h, want %b %0d %0d %h",
                     converged, err_cnt, epoch_cnt, p_final, conv, err, ep, exp_pf);
        end
    endtask

    task automatic test_epoch_limit;
        int cyc, sb;
        logic [3:0] xs;
        logic c;
        xs = 4'($urandom);
        c = 1'($urandom);
        write_mem(0, xs, 1'b0);
        write_mem(1, xs, 1'b1);
        clear_mis;
        for (int e = 0; e < MAXE; e++) begin
            mis[e][0] = c;
            mis[e][1] = ~c;
        end
        start_run(2);
        run_train(2, -1, cyc, sb);
        vec++;
        if (sb !== 0 || cyc !== 21 || converged !== 1'b0 || err_cnt !== 1 || epoch_cnt !== 3 ||
            p_final !== exp_pf) begin
            bad++;
            $display("FAIL epoch_limit: seq_bad=%0d cyc=%0d conv=%b err=%0d ep=%0d pf=%h, want 0 21 0 1 3 %h",
                     sb, cyc, converged, err_cnt, epoch_cnt, p_final, exp_pf);
        end
    endtask

    task automatic test_busy_writes;
        int cyc, sb;
        for (int a = 0; a < 4; a++) write_mem(a, 4'($urandom), 1'($urandom));
        clear_mis;
        p_drv = 16'($urandom);
        start_run(4);
        vec++;
        if (busy !== 1'b1 || epoch_cnt !== 0 || done !== 1'b0) begin
            bad++;
            $display("FAIL restart: busy=%b ep=%0d done=%b, want 1 0 0", busy, epoch_cnt, done);
        end
        run_train(4, 5, cyc, sb);
        exp_pf = p_drv;
        vec++;
        if (sb !== 0 || cyc !== 13 || converged !== 1'b1 || epoch_cnt !== 1 || p_final !== exp_pf) begin
            bad++;
            $display("FAIL busy_ignore: seq_bad=%0d cyc=%0d conv=%b ep=%0d pf=%h, want 0 13 1 1 %h",
                     sb, cyc, converged, epoch_cnt, p_final, exp_pf);
        end
        start_run(4);
        run_train(4, -1, cyc, sb);
        vec++;
        if (sb !== 0 || cyc !== 13) begin
            bad++;
            $display("FAIL busy_mem_kept: seq_bad=%0d cyc=%0d, want 0 13", sb, cyc);
        end
    endtask

    task automatic test_random;
        int n, cyc, sb, ep, err;
        logic conv;
        for (int it = 0; it < 8; it++) begin
            n = $urandom_range(1, DEPTH);
            for (int a = 0; a < n; a++) write_mem(a, 4'($urandom), 1'($urandom));
            for (int e = 0; e < MAXE; e++)
                for (int s = 0; s < DEPTH; s++) mis[e][s] = ($urandom_range(0, n) == 0);
            p_drv = 16'($urandom);
            model(n, ep, err, conv);
            if (conv) exp_pf = p_drv;
            start_run(n);
            run_train(n, -1, cyc, sb);
            vec++;
            if (sb !== 0 || cyc !== ep * (n * DW + 1)) begin
                bad++;
                $display("FAIL random_seq it=%0d n=%0d: seq_bad=%0d cyc=%0d, want 0 %0d",
                         it, n, sb, cyc, ep * (n * DW + 1));
            end
            vec++;
            if (converged !== conv || int'(err_cnt) !== err || int'(epoch_cnt) !== ep || p_final !== exp_pf) begin
                bad++;
                $display("FAIL random_result it=%0d n=%0d: conv=%b err=%0d ep=%0d pf=%h, want %b %0d %0d %h",
                         it, n, converged, err_cnt, epoch_cnt, p_final, conv, err, ep, exp_pf);
            end
        end
    endtask

    initial begin
        test_reset;
        test_convergence;
        test_empty;
        test_dwell;
        test_epoch_limit;
        test_busy_writes;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end
endmodule
